// File: rtl/serial_mag_comp_ctrl_if.sv
// Operand/result handshake bundle for the serial magnitude comparator.
// master: operand producer / result consumer.  slave: the comparator.
// Ports: start_valid/start_ready/x/y (operands in), res_valid/res_ready/gt/lt/eq/bits_scanned (result out).
interface serial_mag_comp_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             res_valid;
  logic             res_ready;
  logic             gt;
  logic             lt;
  logic             eq;
  logic [CW-1:0]    bits_scanned;

  modport master (
    output start_valid, x, y, res_ready,
    input  start_ready, res_valid, gt, lt, eq, bits_scanned
  );

  modport slave (
    input  start_valid, x, y, res_ready,
    output start_ready, res_valid, gt, lt, eq, bits_scanned
  );
endinterface

// File: rtl/serial_mag_comp_ctrl.sv
// Purpose: multi-cycle unsigned magnitude compare of X vs Y, one bit per clock, MSB first.
// Latency: n cycles from accept to res_valid, n = bits_scanned (WIDTH-p on early exit at bit p, else WIDTH).
// Backpressure: result held stable in DONE until res_ready; no new operands accepted until after that handshake.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries the operand and result handshakes.
module serial_mag_comp_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_mag_comp_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] xr_q;
  logic [WIDTH-1:0] yr_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    cnt_q;
  logic             gt_q;
  logic             lt_q;
  logic             eq_q;
  logic             start_ready_q;
  logic             res_valid_q;

  // Single bit-compare step on the current index.
  logic bit_x_d;
  logic bit_y_d;
  logic first_diff_d;
  logic decided_d;

  always_comb begin
    bit_x_d      = xr_q[idx_q];
    bit_y_d      = yr_q[idx_q];
    // Once gt or lt is set the decision is frozen; lower bits cannot override it.
    decided_d    = gt_q | lt_q;
    first_diff_d = (bit_x_d != bit_y_d) && !decided_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      xr_q          <= '0;
      yr_q          <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      gt_q          <= 1'b0;
      lt_q          <= 1'b0;
      eq_q          <= 1'b0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid && start_ready_q) begin
            xr_q          <= bus.x;
            yr_q          <= bus.y;
            idx_q         <= IW'(WIDTH - 1);
            cnt_q         <= '0;
            gt_q          <= 1'b0;
            lt_q          <= 1'b0;
            eq_q          <= 1'b0;
            start_ready_q <= 1'b0;
            state_q       <= SCAN;
          end
        end

        SCAN: begin
          cnt_q <= cnt_q + CW'(1);
          if (first_diff_d) begin
            gt_q <= bit_x_d;
            lt_q <= bit_y_d;
          end
          if (EARLY_EXIT && first_diff_d) begin
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (idx_q == '0) begin
            // Equal only if neither an earlier bit nor this last bit differed.
            eq_q        <= !decided_d && (bit_x_d == bit_y_d);
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end

        DONE: begin
          if (bus.res_ready) begin
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            state_q       <= IDLE;
          end
        end

        default: begin
          state_q       <= IDLE;
          res_valid_q   <= 1'b0;
          start_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.start_ready  = start_ready_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.gt           = gt_q;
  assign bus.lt           = lt_q;
  assign bus.eq           = eq_q;
  assign bus.bits_scanned = cnt_q;

endmodule
